// File: rtl/irq_controller.sv
// Interrupt controller for the Pokemon Mini core: edge-latched flags, enable/priority gating,
// one-at-a-time req/ack delivery. Define IRQ_CTRL_NMI_EN to make source 0 non-maskable.
module irq_controller #(
    parameter logic [23:0] IRQ_PRI = 24'h002020,
    parameter logic [23:0] IRQ_ENA = 24'h002023,
    parameter logic [23:0] IRQ_ACT = 24'h002027
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_ce_cpu,
    input  logic        bus_write,
    input  logic        bus_read,
    input  logic [23:0] bus_address_in,
    input  logic [7:0]  bus_data_in,
    output logic [7:0]  bus_data_out,
    input  logic [15:0] irq_in,
    input  logic [1:0]  cpu_ilevel,
    input  logic        irq_ack,
    output logic        irq_req,
    output logic [3:0]  irq_vector,
    output logic [1:0]  irq_level
);
    typedef enum logic [1:0] {S_IDLE, S_PEND, S_ACKW} state_t;

    state_t            state_q, state_d;
    logic [15:0]       pri_q, ena_q, flag_q, irq_in_q;
    logic [15:0]       flag_d, clr_mask, ack_clr, elig;
    logic [15:0][1:0]  src_pri;
    logic [3:0]        win_vec, vec_q, vec_d;
    logic [1:0]        win_lvl, lvl_q, lvl_d;
    logic              req_q, req_d;
    logic              wr;
    logic              unused_bus_read;

    assign unused_bus_read = bus_read;
    assign wr = clk_ce_cpu & bus_write;

    always_comb begin
        clr_mask = '0;
        if (wr && bus_address_in == IRQ_ACT)          clr_mask[7:0]  = bus_data_in;
        if (wr && bus_address_in == IRQ_ACT + 24'd1)  clr_mask[15:8] = bus_data_in;
    end

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            src_pri[i] = pri_q[(i/2)*2 +: 2];
            elig[i]    = flag_q[i] & ena_q[i] & (src_pri[i] > cpu_ilevel);
        end
`ifdef IRQ_CTRL_NMI_EN
        src_pri[0] = 2'd3;
        elig[0]    = flag_q[0];
`endif
    end

    // Scan high index to low with >= so the lowest index wins a tie; with NMI,
    // source 0 carries level 3 and is scanned last, so it always wins.
    always_comb begin
        win_vec = '0;
        win_lvl = '0;
        for (int i = 15; i >= 0; i--) begin
            if (elig[i] && src_pri[i] >= win_lvl) begin
                win_vec = 4'(i);
                win_lvl = src_pri[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        vec_d   = vec_q;
        lvl_d   = lvl_q;
        ack_clr = '0;
        case (state_q)
            S_IDLE: begin
                if (|elig) begin
                    state_d = S_PEND;
                    req_d   = 1'b1;
                    vec_d   = win_vec;
                    lvl_d   = win_lvl;
                end
            end
            S_PEND: begin
                if (irq_ack) begin
                    ack_clr[vec_q] = 1'b1;
                    req_d          = 1'b0;
                    state_d        = S_ACKW;
                end else if (!elig[vec_q]) begin
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_ACKW: begin
                if (!irq_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A new edge in the same cycle as a clear keeps the flag set.
    assign flag_d = (flag_q & ~(clr_mask | ack_clr)) | (irq_in & ~irq_in_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            req_q    <= 1'b0;
            vec_q    <= '0;
            lvl_q    <= '0;
            pri_q    <= '0;
            ena_q    <= '0;
            flag_q   <= '0;
            irq_in_q <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            vec_q    <= vec_d;
            lvl_q    <= lvl_d;
            flag_q   <= flag_d;
            irq_in_q <= irq_in;
            if (wr) begin
                if (bus_address_in == IRQ_PRI)         pri_q[7:0]  <= bus_data_in;
                if (bus_address_in == IRQ_PRI + 24'd1) pri_q[15:8] <= bus_data_in;
                if (bus_address_in == IRQ_ENA)         ena_q[7:0]  <= bus_data_in;
                if (bus_address_in == IRQ_ENA + 24'd1) ena_q[15:8] <= bus_data_in;
            end
        end
    end

    always_comb begin
        bus_data_out = 8'h00;
        if (bus_address_in == IRQ_PRI)         bus_data_out = pri_q[7:0];
        if (bus_address_in == IRQ_PRI + 24'd1) bus_data_out = pri_q[15:8];
        if (bus_address_in == IRQ_ENA)         bus_data_out = ena_q[7:0];
        if (bus_address_in == IRQ_ENA + 24'd1) bus_data_out = ena_q[15:8];
        if (bus_address_in == IRQ_ACT)         bus_data_out = flag_q[7:0];
        if (bus_address_in == IRQ_ACT + 24'd1) bus_data_out = flag_q[15:8];
    end

    assign irq_req    = req_q;
    assign irq_vector = vec_q;
    assign irq_level  = lvl_q;
endmodule
